// File: rtl/decoder_pkg.sv
// decoder_pkg: shared constants and types for the one-hot decoder family.
//   DEC_IN_W   : binary select width (3)
//   DEC_OUT_W  : one-hot output width (8 = 2**DEC_IN_W)
//   onehot8_t  : 8-bit one-hot (or all-zero) strobe vector
//   is_zero_or_onehot() : true when at most one bit of the vector is set
package decoder_pkg;

    localparam int DEC_IN_W  = 3;
    localparam int DEC_OUT_W = 8;

    typedef logic [DEC_OUT_W-1:0] onehot8_t;

    // Clearing the lowest set bit leaves zero only for 0 or one-hot values.
    function automatic logic is_zero_or_onehot(input onehot8_t v);
        return ((v & (v - onehot8_t'(1))) == '0);
    endfunction

endpackage

// File: rtl/decoder_3to8_en_if.sv
// decoder_3to8_en_if: bundles the decode request (inp, enab) and the
// registered one-hot result (y) for anything that drives or observes the
// 3-to-8 decoder.
//   master : drives inp/enab, observes y
//   slave  : observes inp/enab, drives y
// There is no handshake: a new request is taken on every rising clk edge
// and its result is visible on y after that edge.
interface decoder_3to8_en_if
    import decoder_pkg::*;
#(
    parameter int IN_W  = DEC_IN_W,
    parameter int OUT_W = DEC_OUT_W
);
    logic [IN_W-1:0]  inp;
    logic             enab;
    logic [OUT_W-1:0] y;

    modport master (output inp, output enab, input  y);
    modport slave  (input  inp, input  enab, output y);
endinterface

// File: rtl/decoder_core.sv
// decoder_core: purely combinational binary-to-one-hot decode with enable.
//   inp    : binary select index
//   enab   : active-high enable; low forces next_y to all zeros
//   next_y : one-hot decode of inp, or zero when disabled
module decoder_core #(
    parameter int  IN_W  = 3,
    localparam int OUT_W = 2 ** IN_W
) (
    input  logic [IN_W-1:0]  inp,
    input  logic             enab,
    output logic [OUT_W-1:0] next_y
);

    // Each output bit compares against its own index rather than using a
    // shift, so an unknown select can never light more than one line in
    // the synthesised netlist.
    always_comb begin
        next_y = '0;
        for (int i = 0; i < OUT_W; i++) begin
            if (enab && (inp == IN_W'(i))) begin
                next_y[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/decoder_3to8_en.sv
// decoder_3to8_en: registered 3-to-8 one-hot decoder with enable.
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset; clears y immediately
//   inp  : binary select index 0..7
//   enab : active-high decode enable (has priority over inp)
//   y    : registered one-hot output, one cycle after the inputs
module decoder_3to8_en
    import decoder_pkg::*;
#(
    parameter int IN_W  = DEC_IN_W,
    parameter int OUT_W = DEC_OUT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  inp,
    input  logic             enab,
    output logic [OUT_W-1:0] y
);

    logic [OUT_W-1:0] next_y;

    decoder_core #(
        .IN_W (IN_W)
    ) u_core (
        .inp    (inp),
        .enab   (enab),
        .next_y (next_y)
    );

    // The register is the only state; nothing about the previous select
    // survives a reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y <= '0;
        end else begin
            y <= next_y;
        end
    end

    // Output must always be idle or exactly one strobe.
    a_zero_or_onehot : assert property (
        @(posedge clk) disable iff (rst) is_zero_or_onehot(onehot8_t'(y))
    );

endmodule

// File: tb/tb_decoder_3to8_en.sv
// tb_decoder_3to8_en: directed and random checks of decoder_3to8_en.
module tb_decoder_3to8_en;
    import decoder_pkg::*;

    logic clk;
    logic rst;

    int n_cmp;
    int n_err;

    decoder_3to8_en_if dif ();

    decoder_3to8_en dut (
        .clk  (clk),
        .rst  (rst),
        .inp  (dif.inp),
        .enab (dif.enab),
        .y    (dif.y)
    );

    // clock: posedges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        // Power-on reset, no clock edge yet.
        #1;
        n_cmp++;
        if (dif.y !== 8'h00) begin
            n_err++;
            $display("FAIL reset_por: y=%h required=%h", dif.y, 8'h00);
        end
        // Release and load something non-zero first.
        dif.enab = 1'b1;
        dif.inp  = 3'd5;
        rst = 1'b0;
        step();
        n_cmp++;
        if (dif.y !== 8'h20) begin
            n_err++;
            $display("FAIL reset_preload: y=%h required=%h", dif.y, 8'h20);
        end
        // Mid-cycle async reset with enab=1, inp=3.
        dif.inp = 3'd3;
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (dif.y !== 8'h00) begin
            n_err++;
            $display("FAIL reset_async: y=%h required=%h", dif.y, 8'h00);
        end
        // Hold through an edge.
        step();
        n_cmp++;
        if (dif.y !== 8'h00) begin
            n_err++;
            $display("FAIL reset_hold: y=%h required=%h", dif.y, 8'h00);
        end
        // Release mid-cycle; first edge reflects current inputs.
        #3;
        rst = 1'b0;
        step();
        n_cmp++;
        if (dif.y !== 8'h08) begin
            n_err++;
            $display("FAIL reset_release: y=%h required=%h", dif.y, 8'h08);
        end
    endtask

    task automatic test_disabled();
        dif.enab = 1'b0;
        dif.inp  = 3'd5;
        for (int c = 0; c < 2; c++) begin
            step();
            n_cmp++;
            if (dif.y !== 8'h00) begin
                n_err++;
                $display("FAIL disabled_c%0d: y=%h required=%h", c, dif.y, 8'h00);
            end
        end
    endtask

    task automatic test_sweep();
        logic [7:0] sweep_exp [8];
        sweep_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        dif.enab = 1'b1;
        for (int i = 0; i < 8; i++) begin
            dif.inp = 3'(i);
            step();
            n_cmp++;
            if (dif.y !== sweep_exp[i]) begin
                n_err++;
                $display("FAIL sweep_inp%0d: y=%h required=%h", i, dif.y, sweep_exp[i]);
            end
        end
    endtask

    task automatic test_enable_drop();
        dif.enab = 1'b1;
        dif.inp  = 3'd7;
        step();
        n_cmp++;
        if (dif.y !== 8'h80) begin
            n_err++;
            $display("FAIL drop_before: y=%h required=%h", dif.y, 8'h80);
        end
        dif.enab = 1'b0;
        dif.inp  = 3'd0;
        step();
        n_cmp++;
        if (dif.y !== 8'h00) begin
            n_err++;
            $display("FAIL drop_after: y=%h required=%h", dif.y, 8'h00);
        end
    endtask

    task automatic test_latency();
        dif.enab = 1'b1;
        dif.inp  = 3'd2;
        step();
        n_cmp++;
        if (dif.y !== 8'h04) begin
            n_err++;
            $display("FAIL latency_prior: y=%h required=%h", dif.y, 8'h04);
        end
        #2;
        dif.inp = 3'd6;
        #1;
        n_cmp++;
        if (dif.y !== 8'h04) begin
            n_err++;
            $display("FAIL latency_mid6: y=%h required=%h", dif.y, 8'h04);
        end
        #1;
        dif.inp = 3'd1;
        #1;
        n_cmp++;
        if (dif.y !== 8'h04) begin
            n_err++;
            $display("FAIL latency_mid1: y=%h required=%h", dif.y, 8'h04);
        end
        step();
        n_cmp++;
        if (dif.y !== 8'h02) begin
            n_err++;
            $display("FAIL latency_edge: y=%h required=%h", dif.y, 8'h02);
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        logic [7:0] exp_y;
        logic [7:0] got;
        for (int c = 0; c < 1000; c++) begin
            dif.inp  = 3'($urandom_range(0, 7));
            dif.enab = 1'($urandom_range(0, 1));
            exp_q.push_back(dif.enab ? (8'h01 << dif.inp) : 8'h00);
            // Occasional async pulse, released before the next edge.
            if ($urandom_range(0, 19) == 0) begin
                #2;
                rst = 1'b1;
                #1;
                n_cmp++;
                if (dif.y !== 8'h00) begin
                    n_err++;
                    $display("FAIL rand_async_c%0d: y=%h required=%h", c, dif.y, 8'h00);
                end
                #1;
                rst = 1'b0;
            end
            step();
            got   = dif.y;
            exp_y = exp_q.pop_front();
            n_cmp++;
            if (got !== exp_y) begin
                n_err++;
                $display("FAIL rand_model_c%0d: y=%h required=%h", c, got, exp_y);
            end
            n_cmp++;
            if ((got & (got - 8'h01)) !== 8'h00) begin
                n_err++;
                $display("FAIL rand_onehot_c%0d: y=%h required=zero_or_onehot", c, got);
            end
        end
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_err++;
            $display("FAIL rand_queue: left=%0d required=0", exp_q.size());
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst      = 1'b1;
        dif.inp  = '0;
        dif.enab = 1'b0;
        test_reset();
        test_disabled();
        test_sweep();
        test_enable_drop();
        test_latency();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
